isdft: RTL and testbench
========================

# isdft

Inverse partner of the `sdft` block: an inverse-DFT synthesiser that turns a bank of complex frequency bins back into a stream of signed time-domain samples. Bins are loaded through a write port. While `run` is high, the block computes x[n] = (1/N)·Re(Σ_k X[k]·e^(+j2πkn/N)) with a single time-multiplexed complex MAC, one bin per cycle. Each finished sample is presented on a valid/ready output. It sits after the sdft (or any bin-domain processing) to regenerate the signal.

## Interface
- `data_width`, default 8: width of the signed output sample.
- `freq_bins`, default 16: N; must be a power of two, ≥ 4.
- `bin_width`, default 12: signed width of each bin's real and imaginary parts.
- `twiddle_width`, default 8: signed twiddle width. Twiddles are scaled by 2^(twiddle_width-2) and rounded to nearest.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `bin_we`  in  1: bin write strobe.
- `bin_addr`  in  clog2(freq_bins): bin index k.
- `bin_real`, `bin_imag`  in  bin_width each, signed: bin value written.
- `run`  in  1: level enable for continuous synthesis.
- `out_sample`  out  data_width, signed: synthesised sample.
- `out_index`  out  clog2(freq_bins): time index n of `out_sample`.
- `out_valid`  out  1: sample available.
- `out_ready`  in  1: consumer accepts the sample.
- `busy`  out  1: high in MAC or OUT.

## Operation
- Bin store: two register arrays of N entries each, read combinationally, written on `bin_we` at the clock edge. Writes are accepted in every state. A MAC read of the same address in the same cycle sees the old value.
- Twiddle ROM: N entries each of cos and sin of 2πm/N, indexed by m = (k·n) mod N. The product is truncated to clog2(N) bits, so wrap-around is free.
- State machine:
  - IDLE → MAC when `run` is high.
  - MAC: k runs from 0 to N-1, one complex product per cycle. After k = N-1 the block goes to OUT.
  - OUT → MAC if `out_valid && out_ready` and `run` is high.
  - OUT → IDLE if `out_valid && out_ready` and `run` is low.
  - OUT holds otherwise.
- MAC arithmetic:
  - Each cycle: acc += X_re[k]·cos(m) − X_im[k]·sin(m).
  - acc is signed, bin_width + twiddle_width + clog2(N) + 1 bits, and is cleared on entry to MAC.
  - Only the real part is produced; the bins are assumed conjugate-symmetric.
- Output scaling:
  - y = acc >>> (twiddle_width − 2 + clog2(N)), an arithmetic floor shift.
  - y is saturated to [−2^(data_width−1), 2^(data_width−1)−1].
  - The result is registered into `out_sample` on the MAC → OUT transition.
- Time index n is incremented modulo N on each accepted sample, wrapping N−1 → 0. `out_index` equals n while in OUT.
- `run` dropping during MAC: the current sample completes and is presented, then the block returns to IDLE. n is retained, so the next `run` resumes at the following n.

## Timing
- Reset values: state IDLE, n = 0, k = 0, acc = 0, all bins 0, `out_sample` = 0, `out_index` = 0, `out_valid` = 0, `busy` = 0.
- Latency: `out_valid` rises N+1 edges after the first edge at which `run` is sampled high in IDLE. That is 1 edge into MAC, then N MAC edges.
- Throughput: N+1 cycles per sample with `out_ready` held high.
- `out_valid` stays high and `out_sample`/`out_index` stay stable until the handshake completes. It drops the cycle after acceptance unless the next sample is already complete, which is impossible because MAC takes N cycles.
- Reset asserted mid-MAC or mid-OUT aborts immediately: all state returns to reset values and no partial sample is emitted.

## Structure
- Shared package: state encoding (IDLE/MAC/OUT), the twiddle scale constant, and the clog2 helper shared with `sdft`.
- One sub-module: `twiddle_rom`, parameterised by N and twiddle_width, returning cos/sin for index m. The same ROM serves `sdft` with the sin sign flipped.

## Test plan
- Defaults. Set X[0] = 160, all other bins 0, `run` high, `out_ready` high → samples 10,10,10,… with `out_index` 0,1,…,15,0. Each `out_valid` pulse is 17 cycles apart; the first comes 17 edges after `run`.
- Set X[4] = X[12] = 80 (imag 0) → 10, 0, −10, 0 repeating.
- Saturation: X[0] = X[4] = X[12] = 2047 → n = 0 gives 127 (saturated); n = 2 gives −128.
- Backpressure: `out_ready` low for 5 cycles during OUT → `out_valid`, `out_sample` and `out_index` stable; no sample is lost or duplicated.
- `run` dropped mid-MAC at n = 3 → sample 3 is delivered, then IDLE with `busy` = 0. Re-raising `run` produces n = 4 next.
- Reset asserted mid-MAC → all outputs 0 on the same edge. After release with `run` high, the first sample is n = 0 computed from zeroed bins, so the output is 0.

Source files
------------

// File: rtl/isdft_pkg.sv
// Shared definitions for the isdft/sdft pair: state encoding, twiddle scaling
// and the log2 helper used to size index ports.
package isdft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Twiddles are scaled by 2^(twiddle_width - TWIDDLE_HEADROOM) so that +1.0 fits.
    localparam int TWIDDLE_HEADROOM = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int twiddle_shift(input int twiddle_width);
        return twiddle_width - TWIDDLE_HEADROOM;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Constant cos/sin table for 2*pi*m/N, rounded to nearest at the package scale.
// sdft uses the same table with the sin sign flipped.
module twiddle_rom
    import isdft_pkg::*;
#(
    parameter int freq_bins     = 16,
    parameter int twiddle_width = 8,
    localparam int addr_width   = clog2(freq_bins)
) (
    input  logic [addr_width-1:0]          idx,
    output logic signed [twiddle_width-1:0] cos_val,
    output logic signed [twiddle_width-1:0] sin_val
);

    localparam real PI = 3.14159265358979323846;

    function automatic real wrapped_angle(input int m);
        real a;
        a = 2.0 * PI * real'(m) / real'(freq_bins);
        if (a > PI) a = a - 2.0 * PI;
        return a;
    endfunction

    // Taylor series on an angle folded into [-pi, pi]; evaluated at elaboration only.
    function automatic real series(input real x, input bit odd);
        real term;
        real sum;
        term = odd ? x : 1.0;
        sum  = term;
        for (int i = 1; i < 25; i++) begin
            if (odd) term = -term * x * x / real'((2 * i) * (2 * i + 1));
            else     term = -term * x * x / real'((2 * i - 1) * (2 * i));
            sum = sum + term;
        end
        return sum;
    endfunction

    function automatic logic signed [twiddle_width-1:0] quantise(input real v);
        real s;
        int  q;
        s = v * real'(1 << twiddle_shift(twiddle_width));
        if (s >= 0.0) q = $rtoi(s + 0.5);
        else          q = -$rtoi(-s + 0.5);
        return twiddle_width'(q);
    endfunction

    logic signed [twiddle_width-1:0] cos_tab [freq_bins];
    logic signed [twiddle_width-1:0] sin_tab [freq_bins];

    for (genvar m = 0; m < freq_bins; m++) begin : g_tab
        localparam logic signed [twiddle_width-1:0] COS_Q = quantise(series(wrapped_angle(m), 1'b0));
        localparam logic signed [twiddle_width-1:0] SIN_Q = quantise(series(wrapped_angle(m), 1'b1));
        assign cos_tab[m] = COS_Q;
        assign sin_tab[m] = SIN_Q;
    end

    assign cos_val = cos_tab[idx];
    assign sin_val = sin_tab[idx];

endmodule

// File: rtl/isdft.sv
// Inverse-DFT synthesiser: one complex MAC per cycle over N stored bins,
// producing one real time-domain sample per N+1 cycles on a valid/ready port.
module isdft
    import isdft_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int freq_bins     = 16,
    parameter int bin_width     = 12,
    parameter int twiddle_width = 8,
    localparam int addr_width   = clog2(freq_bins)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bin_we,
    input  logic [addr_width-1:0]        bin_addr,
    input  logic signed [bin_width-1:0]  bin_real,
    input  logic signed [bin_width-1:0]  bin_imag,
    input  logic                         run,
    output logic signed [data_width-1:0] out_sample,
    output logic [addr_width-1:0]        out_index,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int acc_width = bin_width + twiddle_width + addr_width + 1;
    localparam int out_shift = twiddle_shift(twiddle_width) + addr_width;
    localparam logic [addr_width-1:0] k_last = addr_width'(freq_bins - 1);
    localparam logic signed [data_width-1:0] sat_hi = {1'b0, {(data_width-1){1'b1}}};
    localparam logic signed [data_width-1:0] sat_lo = {1'b1, {(data_width-1){1'b0}}};
    localparam logic signed [acc_width-1:0] y_max = {{(acc_width-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
    localparam logic signed [acc_width-1:0] y_min = {{(acc_width-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

    logic signed [bin_width-1:0] bin_re [freq_bins];
    logic signed [bin_width-1:0] bin_im [freq_bins];

    state_t                          state;
    logic [addr_width-1:0]           n;
    logic [addr_width-1:0]           k;
    logic signed [acc_width-1:0]     acc;

    logic [addr_width-1:0]           tw_idx;
    logic signed [twiddle_width-1:0] cos_val;
    logic signed [twiddle_width-1:0] sin_val;
    logic signed [bin_width-1:0]     re_k;
    logic signed [bin_width-1:0]     im_k;
    logic signed [acc_width-1:0]     re_ext;
    logic signed [acc_width-1:0]     im_ext;
    logic signed [acc_width-1:0]     cos_ext;
    logic signed [acc_width-1:0]     sin_ext;
    logic signed [acc_width-1:0]     acc_next;
    logic signed [acc_width-1:0]     y_shift;
    logic signed [data_width-1:0]    y_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < freq_bins; i++) begin
                bin_re[i] <= '0;
                bin_im[i] <= '0;
            end
        end else if (bin_we) begin
            bin_re[bin_addr] <= bin_real;
            bin_im[bin_addr] <= bin_imag;
        end
    end

    // Index product truncated to addr_width bits gives (k*n) mod N for free.
    assign tw_idx = k * n;

    twiddle_rom #(
        .freq_bins    (freq_bins),
        .twiddle_width(twiddle_width)
    ) u_twiddle_rom (
        .idx    (tw_idx),
        .cos_val(cos_val),
        .sin_val(sin_val)
    );

    assign re_k    = bin_re[k];
    assign im_k    = bin_im[k];
    assign re_ext  = {{(acc_width-bin_width){re_k[bin_width-1]}}, re_k};
    assign im_ext  = {{(acc_width-bin_width){im_k[bin_width-1]}}, im_k};
    assign cos_ext = {{(acc_width-twiddle_width){cos_val[twiddle_width-1]}}, cos_val};
    assign sin_ext = {{(acc_width-twiddle_width){sin_val[twiddle_width-1]}}, sin_val};

    assign acc_next = acc + re_ext * cos_ext - im_ext * sin_ext;
    assign y_shift  = acc_next >>> out_shift;

    always_comb begin
        y_sat = y_shift[data_width-1:0];
        if (y_shift > y_max)      y_sat = sat_hi;
        else if (y_shift < y_min) y_sat = sat_lo;
    end

    assign out_index = n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            n          <= '0;
            k          <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_MAC;
                        k     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    if (k == k_last) begin
                        state      <= ST_OUT;
                        out_sample <= y_sat;
                        out_valid  <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        n         <= n + 1'b1;
                        if (run) begin
                            state <= ST_MAC;
                            k     <= '0;
                            acc   <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isdft.sv
// Scoreboard bench for isdft: stimulus pushes hand-computed samples into a
// queue, a negedge monitor pops and compares every accepted output.
module tb_isdft;

    logic              clk;
    logic              reset;
    logic              bin_we;
    logic [3:0]        bin_addr;
    logic signed [11:0] bin_real;
    logic signed [11:0] bin_imag;
    logic              run;
    logic signed [7:0] out_sample;
    logic [3:0]        out_index;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    isdft dut (
        .clk       (clk),
        .reset     (reset),
        .bin_we    (bin_we),
        .bin_addr  (bin_addr),
        .bin_real  (bin_real),
        .bin_imag  (bin_imag),
        .run       (run),
        .out_sample(out_sample),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    typedef struct {
        int s;
        int i;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pops = 0;
    int   cyc = 0;
    int   n_model = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected sample per bin pattern; n only matters modulo 4 for these patterns.
    function automatic int expected(input int pat, input int n);
        int t1 [4] = '{10, 0, -10, 0};
        int t2 [4] = '{127, 127, -128, 127};
        case (pat)
            0:       return 10;
            1:       return t1[n % 4];
            2:       return t2[n % 4];
            default: return 0;
        endcase
    endfunction

    // Monitor: a handshake seen here completes at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_sample: got %0d at index %0d, expected none", out_sample, out_index);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", int'(out_sample), e.s);
                    check("index", int'(out_index), e.i);
                end
                acc_cyc.push_back(cyc);
                pops++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic write_bin(input int k, input int re, input int im);
        bin_we   = 1'b1;
        bin_addr = 4'(k);
        bin_real = 12'(re);
        bin_imag = 12'(im);
        @(posedge clk); #1;
        bin_we   = 1'b0;
    endtask

    // Runs `count` samples; run is dropped mid-MAC of the last one.
    task automatic run_batch(input int count, input int pat, input bit stall);
        int   base;
        int   lat;
        bit   seen;
        exp_t e;
        base = pops;
        for (int j = 0; j < count; j++) begin
            exp_q.push_back('{expected(pat, n_model), n_model});
            n_model = (n_model + 1) % 16;
        end
        out_ready = !stall;
        run  = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1 && count == 1) run = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        check("latency", lat, 17);
        if (stall) begin
            e = exp_q[0];
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check("stall_valid", int'(out_valid), 1);
                check("stall_sample", int'(out_sample), e.s);
                check("stall_index", int'(out_index), e.i);
            end
            out_ready = 1'b1;
        end
        if (count > 1) begin
            for (int c = 0; c < 40 * count && pops < base + count - 1; c++) begin
                @(posedge clk); #1;
            end
            run = 1'b0;
        end
        for (int c = 0; c < 100 && (pops < base + count || busy); c++) begin
            @(posedge clk); #1;
        end
        check("batch_count", pops - base, count);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        reset     = 1'b1;
        bin_we    = 1'b0;
        bin_addr  = '0;
        bin_real  = '0;
        bin_imag  = '0;
        run       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", int'(out_sample), 0);
        check("rst_index", int'(out_index), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // DC bin: constant 10 over a full period plus wrap to n=0.
        write_bin(0, 160, 0);
        acc_cyc.delete();
        run_batch(17, 0, 1'b0);
        for (int i = 1; i < 17 && i < acc_cyc.size(); i++)
            check("gap", acc_cyc[i] - acc_cyc[i-1], 17);

        // Quarter-rate cosine: 10, 0, -10, 0; starts at n=1.
        write_bin(0, 0, 0);
        write_bin(4, 80, 0);
        write_bin(12, 80, 0);
        run_batch(8, 1, 1'b0);

        // Saturation: n=9..15 then n=0.
        write_bin(0, 2047, 0);
        write_bin(4, 2047, 0);
        write_bin(12, 2047, 0);
        run_batch(8, 2, 1'b0);

        // Backpressure on n=1, then n=2.
        run_batch(2, 2, 1'b1);

        // run dropped mid-MAC at n=3, resume at n=4.
        write_bin(0, 0, 0);
        write_bin(4, 80, 0);
        write_bin(12, 80, 0);
        run_batch(1, 1, 1'b0);
        run_batch(1, 1, 1'b0);

        // Reset mid-MAC clears outputs and bins immediately.
        out_ready = 1'b1;
        run = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sample", int'(out_sample), 0);
        check("mid_rst_index", int'(out_index), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        n_model = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_batch(1, 3, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
